// File: rtl/auth_msg_initiator_pkg.sv
// Shared types and constants for the authentication message initiator.
// Message width comes from `MSG_LEN (default 64).
`ifndef MSG_LEN
`define MSG_LEN 64
`endif

package auth_msg_initiator_pkg;

  localparam int MSG_LEN = `MSG_LEN;

  localparam logic [7:0] AUTH_VERSION   = 8'h01;
  localparam logic [7:0] TYPE_DIGESTS   = 8'h81;
  localparam logic [7:0] TYPE_CERT      = 8'h82;
  localparam logic [7:0] TYPE_CHALLENGE = 8'h83;

  typedef enum logic [1:0] {
    FLD_NONE      = 2'b00,
    FLD_DIGESTS   = 2'b01,
    FLD_CERT      = 2'b10,
    FLD_CHALLENGE = 2'b11
  } field_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SEND,
    S_WAIT_RESP,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  function automatic logic [7:0] req_type(
    input logic [1:0] code
  );
    logic [7:0] t;
    t = 8'h00;
    case (code)
      FLD_DIGESTS:   t = TYPE_DIGESTS;
      FLD_CERT:      t = TYPE_CERT;
      FLD_CHALLENGE: t = TYPE_CHALLENGE;
      default:       t = 8'h00;
    endcase
    return t;
  endfunction

  // {version, type, field index, chunk index, zero padding}
  function automatic logic [MSG_LEN-1:0] build_msg(
    input logic [7:0] ty,
    input logic [1:0] idx,
    input logic [7:0] chunk
  );
    logic [MSG_LEN-1:0] m;
    m = '0;
    m[MSG_LEN-1 -: 32] = {AUTH_VERSION, ty, 6'd0, idx, chunk};
    return m;
  endfunction

endpackage

// File: rtl/auth_msg_initiator_timeout.sv
// auth_timeout_counter: counts enabled cycles since the last load.
// Ports: clk, reset, load, enable in; expired out (LIMIT cycles reached).
module auth_timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt;

  // Counter value k during the k-th cycle after load; the last allowed
  // cycle is LIMIT-1, so expired lets the FSM leave after LIMIT cycles.
  assign expired = enable && (cnt == 16'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/auth_msg_initiator.sv
// Serves 2-bit request fields from PD (and DEBUG with AUTH_DEBUG_PORT_EN)
// as host request messages; checks response headers; pulses erase/ready.
// Ports: source ready/byte/erase/ready, auth_msg_* to host, resp_* pop,
// auth_resp_* result, sticky auth_error.
module auth_msg_initiator
  import auth_msg_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CERT_CHUNKS    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PD_msg_ready,
  input  logic               DEBUG_msg_ready,
  input  logic [7:0]         pending_auth_request_PD,
  input  logic [7:0]         pending_auth_request_DEBUG,
  output logic               pending_auth_request_PD_erase,
  output logic               pending_auth_request_DEBUG_erase,
  output logic               PD_ready,
  output logic               DEBUG_ready,
  output logic [MSG_LEN-1:0] auth_msg_out,
  output logic               auth_msg_ready,
  input  logic               Ack_in_driver,
  input  logic               resp_req_in,
  output logic               resp_req_out,
  input  logic [MSG_LEN-1:0] auth_msg_in,
  output logic [MSG_LEN-1:0] auth_resp_data,
  output logic               auth_resp_valid,
  output logic               auth_error
);

  state_e     state, next_state;
  logic [7:0] req_byte;
  logic       src_dbg;
  logic [1:0] fld_idx;
  logic [7:0] chunk;
  logic       err_q;

  logic       pd_req, dbg_req;
  logic       found;
  logic [1:0] found_idx;
  logic [1:0] cur_code;
  logic [7:0] cur_type;
  logic       hdr_ok;
  logic       more;
  logic       expired;
  logic       tmr_load, tmr_en;

  assign pd_req = PD_msg_ready;
`ifdef AUTH_DEBUG_PORT_EN
  assign dbg_req = DEBUG_msg_ready;
`else
  logic unused_dbg;
  assign unused_dbg = ^{DEBUG_msg_ready, pending_auth_request_DEBUG};
  assign dbg_req    = 1'b0;
`endif

  // Lowest-index nonzero field wins: scan high to low, last hit sticks.
  always_comb begin
    found     = 1'b0;
    found_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_byte[2*i +: 2] != 2'b00) begin
        found     = 1'b1;
        found_idx = 2'(i);
      end
    end
  end

  assign cur_code = req_byte[2*fld_idx +: 2];
  assign cur_type = req_type(cur_code);
  assign hdr_ok   = auth_resp_data[MSG_LEN-1 -: 16] == {AUTH_VERSION, cur_type};
  assign more     = (cur_code == FLD_CERT) && (chunk < 8'(CERT_CHUNKS - 1));

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:
        if (pd_req || dbg_req) next_state = S_DECODE;
      S_DECODE:
        next_state = found ? S_SEND : S_DONE;
      S_SEND:
        if (Ack_in_driver) next_state = S_WAIT_RESP;
        else if (expired)  next_state = S_ERROR;
      S_WAIT_RESP:
        if (resp_req_in)  next_state = S_CHECK;
        else if (expired) next_state = S_ERROR;
      S_CHECK:
        if (!hdr_ok)   next_state = S_ERROR;
        else if (more) next_state = S_SEND;
        else           next_state = S_DECODE;
      S_DONE:  next_state = S_IDLE;
      S_ERROR: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign tmr_en   = (state == S_SEND) || (state == S_WAIT_RESP);
  assign tmr_load = ((next_state == S_SEND) && (state != S_SEND)) ||
                    ((next_state == S_WAIT_RESP) && (state != S_WAIT_RESP));

  auth_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .enable (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      req_byte       <= '0;
      src_dbg        <= 1'b0;
      fld_idx        <= '0;
      chunk          <= '0;
      err_q          <= 1'b0;
      auth_msg_out   <= '0;
      auth_resp_data <= '0;
    end else begin
      state <= next_state;
      if (next_state == S_ERROR) err_q <= 1'b0 | 1'b1;
      unique case (state)
        S_IDLE:
          if (pd_req) begin
            req_byte <= pending_auth_request_PD;
            src_dbg  <= 1'b0;
            err_q    <= 1'b0;
          end else if (dbg_req) begin
            req_byte <= pending_auth_request_DEBUG;
            src_dbg  <= 1'b1;
            err_q    <= 1'b0;
          end
        S_DECODE:
          if (found) begin
            fld_idx      <= found_idx;
            chunk        <= 8'd0;
            auth_msg_out <= build_msg(req_type(req_byte[2*found_idx +: 2]),
                                      found_idx, 8'd0);
          end
        S_WAIT_RESP:
          if (resp_req_in) auth_resp_data <= auth_msg_in;
        S_CHECK:
          if (hdr_ok && more) begin
            chunk        <= chunk + 8'd1;
            auth_msg_out <= build_msg(cur_type, fld_idx, chunk + 8'd1);
          end else if (hdr_ok) begin
            req_byte[2*fld_idx +: 2] <= 2'b00;
          end
        default: ;
      endcase
    end
  end

  assign auth_msg_ready  = (state == S_SEND);
  assign resp_req_out    = (state == S_WAIT_RESP) && resp_req_in;
  assign auth_resp_valid = (state == S_CHECK) && hdr_ok;
  assign auth_error      = err_q;

  assign PD_ready = (state == S_DONE) && !src_dbg;
  assign pending_auth_request_PD_erase =
    ((state == S_DONE) || (state == S_ERROR)) && !src_dbg;

`ifdef AUTH_DEBUG_PORT_EN
  assign DEBUG_ready = (state == S_DONE) && src_dbg;
  assign pending_auth_request_DEBUG_erase =
    ((state == S_DONE) || (state == S_ERROR)) && src_dbg;
`else
  assign DEBUG_ready = 1'b0;
  assign pending_auth_request_DEBUG_erase = 1'b0;
`endif

endmodule

// File: tb/tb_auth_msg_initiator.sv
// Directed bench for auth_msg_initiator: single/multi-field service,
// arbitration, header error, timeout and mid-transaction reset.
module tb_auth_msg_initiator;
  import auth_msg_initiator_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               PD_msg_ready = 1'b0;
  logic               DEBUG_msg_ready = 1'b0;
  logic [7:0]         pend_pd = 8'h00;
  logic [7:0]         pend_dbg = 8'h00;
  logic               pd_erase, dbg_erase, PD_ready, DEBUG_ready;
  logic [MSG_LEN-1:0] auth_msg_out;
  logic               auth_msg_ready;
  logic               Ack_in_driver = 1'b0;
  logic               resp_req_in = 1'b0;
  logic               resp_req_out;
  logic [MSG_LEN-1:0] auth_msg_in = '0;
  logic [MSG_LEN-1:0] auth_resp_data;
  logic               auth_resp_valid;
  logic               auth_error;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0, n_pd_rdy = 0, n_pd_era = 0, n_dbg_rdy = 0, n_dbg_era = 0;

  always #5 clk = ~clk;

  auth_msg_initiator #(
    .TIMEOUT_CYCLES(1024),
    .CERT_CHUNKS   (6)
  ) dut (
    .clk                             (clk),
    .reset                           (reset),
    .PD_msg_ready                    (PD_msg_ready),
    .DEBUG_msg_ready                 (DEBUG_msg_ready),
    .pending_auth_request_PD         (pend_pd),
    .pending_auth_request_DEBUG      (pend_dbg),
    .pending_auth_request_PD_erase   (pd_erase),
    .pending_auth_request_DEBUG_erase(dbg_erase),
    .PD_ready                        (PD_ready),
    .DEBUG_ready                     (DEBUG_ready),
    .auth_msg_out                    (auth_msg_out),
    .auth_msg_ready                  (auth_msg_ready),
    .Ack_in_driver                   (Ack_in_driver),
    .resp_req_in                     (resp_req_in),
    .resp_req_out                    (resp_req_out),
    .auth_msg_in                     (auth_msg_in),
    .auth_resp_data                  (auth_resp_data),
    .auth_resp_valid                 (auth_resp_valid),
    .auth_error                      (auth_error)
  );

  // Pulse counters, sampled on the edge that consumes them.
  always @(posedge clk) begin
    if (!reset) begin
      if (auth_resp_valid) n_valid++;
      if (PD_ready)        n_pd_rdy++;
      if (pd_erase)        n_pd_era++;
      if (DEBUG_ready)     n_dbg_rdy++;
      if (dbg_erase)       n_dbg_era++;
    end
  end

  task automatic chk(input string tag,
                     input logic [MSG_LEN-1:0] got,
                     input logic [MSG_LEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [MSG_LEN-1:0] exp_msg(input logic [7:0] ty,
                                                 input logic [7:0] fld,
                                                 input logic [7:0] ch);
    logic [MSG_LEN-1:0] m;
    m = '0;
    m[MSG_LEN-1 -: 32] = {8'h01, ty, fld, ch};
    return m;
  endfunction

  task automatic pd_req(input logic [7:0] b);
    @(negedge clk);
    PD_msg_ready = 1'b1;
    pend_pd = b;
    @(negedge clk);
    PD_msg_ready = 1'b0;
  endtask

  task automatic wait_msg(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (auth_msg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("msg_timeout", 0, 1);
  endtask

  // Host side of one request/response exchange.
  task automatic serve(input logic [7:0] ty, input logic [7:0] fld,
                       input logic [7:0] ch, input logic [15:0] hdr);
    bit ok;
    logic [MSG_LEN-1:0] r;
    wait_msg(ok);
    if (ok) begin
      chk("msg", auth_msg_out, exp_msg(ty, fld, ch));
      Ack_in_driver = 1'b1;
      @(negedge clk);
      Ack_in_driver = 1'b0;
      chk("ready_drop", auth_msg_ready, 0);
      r = '0;
      r[MSG_LEN-1 -: 24] = {hdr, 8'hA5 ^ ch};
      auth_msg_in = r;
      resp_req_in = 1'b1;
      #1;
      chk("resp_pop", resp_req_out, 1);
      @(negedge clk);
      resp_req_in = 1'b0;
      chk("resp_pop_1cyc", resp_req_out, 0);
      chk("resp_valid", auth_resp_valid, hdr == {8'h01, ty});
      chk("resp_data", auth_resp_data, r);
    end
  endtask

  task automatic wait_pd_rdy(input int target);
    for (int i = 0; i < 200 && n_pd_rdy < target; i++) @(negedge clk);
    chk("pd_ready_cnt", n_pd_rdy, target);
  endtask

  initial begin
    int hi;
    int b_valid, b_era;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_msg_ready", auth_msg_ready, 0);
    chk("rst_msg_out", auth_msg_out, 0);
    chk("rst_error", auth_error, 0);
    chk("rst_erase", pd_erase, 0);
    chk("rst_resp_data", auth_resp_data, 0);
    reset = 1'b0;

    // Single CHALLENGE
    pd_req(8'h03);
    serve(TYPE_CHALLENGE, 8'd0, 8'd0, 16'h0183);
    wait_pd_rdy(1);
    chk("t1_valid", n_valid, 1);
    chk("t1_erase", n_pd_era, 1);
    chk("t1_error", auth_error, 0);

    // CHALLENGE then six certificate chunks
    pd_req(8'h23);
    serve(TYPE_CHALLENGE, 8'd0, 8'd0, 16'h0183);
    for (int c = 0; c < 6; c++) serve(TYPE_CERT, 8'd2, 8'(c), 16'h0182);
    wait_pd_rdy(2);
    chk("t2_valid", n_valid, 8);
    chk("t2_erase", n_pd_era, 2);
    repeat (3) @(negedge clk);
    chk("t2_no_more_msg", auth_msg_ready, 0);

    // Wrong response header
    b_era = n_pd_era;
    pd_req(8'h02);
    serve(TYPE_CERT, 8'd0, 8'd0, 16'h0181);
    @(negedge clk);
    chk("t3_error", auth_error, 1);
    chk("t3_erase_pulse", pd_erase, 1);
    chk("t3_no_ready", PD_ready, 0);
    repeat (3) @(negedge clk);
    chk("t3_valid", n_valid, 8);
    chk("t3_erase_cnt", n_pd_era, b_era + 1);
    chk("t3_ready_cnt", n_pd_rdy, 2);
    chk("t3_error_sticky", auth_error, 1);

    // Ack never arrives
    pd_req(8'h01);
    chk("t4_error_clr", auth_error, 0);
    hi = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (auth_msg_ready) hi++;
      else if (hi > 0) break;
    end
    chk("t4_ready_cycles", hi, 1024);
    chk("t4_error", auth_error, 1);
    chk("t4_erase", pd_erase, 1);
    repeat (3) @(negedge clk);
    chk("t4_no_ready", n_pd_rdy, 2);
    chk("t4_erase_cnt", n_pd_era, b_era + 2);

    // PD and DEBUG in the same cycle
    b_valid = n_valid;
    @(negedge clk);
    PD_msg_ready = 1'b1;
    pend_pd = 8'h01;
    DEBUG_msg_ready = 1'b1;
    pend_dbg = 8'h03;
    @(negedge clk);
    PD_msg_ready = 1'b0;
    serve(TYPE_DIGESTS, 8'd0, 8'd0, 16'h0181);
    wait_pd_rdy(3);
`ifdef AUTH_DEBUG_PORT_EN
    begin
      bit ok;
      wait_msg(ok);
      DEBUG_msg_ready = 1'b0;
      if (ok) chk("t5_dbg_msg", auth_msg_out, exp_msg(TYPE_CHALLENGE, 8'd0, 8'd0));
    end
    serve(TYPE_CHALLENGE, 8'd0, 8'd0, 16'h0183);
    for (int i = 0; i < 50 && n_dbg_rdy == 0; i++) @(negedge clk);
    chk("t5_dbg_ready", n_dbg_rdy, 1);
    chk("t5_dbg_erase", n_dbg_era, 1);
    chk("t5_valid", n_valid, b_valid + 2);
`else
    repeat (20) begin
      @(negedge clk);
      chk("t5_dbg_ignored", auth_msg_ready, 0);
    end
    DEBUG_msg_ready = 1'b0;
    chk("t5_dbg_ready", n_dbg_rdy, 0);
    chk("t5_dbg_erase", n_dbg_era, 0);
    chk("t5_valid", n_valid, b_valid + 1);
`endif

    // Reset while waiting for the response
    b_era = n_pd_era;
    pd_req(8'h01);
    begin
      bit ok;
      wait_msg(ok);
      Ack_in_driver = 1'b1;
      @(negedge clk);
      Ack_in_driver = 1'b0;
    end
    #2 reset = 1'b1;
    resp_req_in = 1'b1;
    #1;
    chk("t6_msg_ready", auth_msg_ready, 0);
    chk("t6_msg_out", auth_msg_out, 0);
    chk("t6_resp_pop", resp_req_out, 0);
    chk("t6_resp_data", auth_resp_data, 0);
    chk("t6_erase", pd_erase, 0);
    @(negedge clk);
    resp_req_in = 1'b0;
    reset = 1'b0;
    chk("t6_erase_cnt", n_pd_era, b_era);
    pd_req(8'h03);
    serve(TYPE_CHALLENGE, 8'd0, 8'd0, 16'h0183);
    wait_pd_rdy(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/auth_msg_initiator.md
AUTH_MSG_INITIATOR -- requirements
Module: auth_msg_initiator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, clk cycles allowed in SEND or WAIT_RESP before abort; range 2..65535.
REQ-002 Parameter: CERT_CHUNKS, 6, GET_CERTIFICATE response chunks per certificate request.
REQ-003 Width: MSG_LEN from the shared `MSG_LEN define.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 PD_msg_ready / DEBUG_msg_ready  in  1 each  source has a pending request byte (level).
REQ-007 pending_auth_request_PD / pending_auth_request_DEBUG  in  8 each  four 2-bit request fields, [1:0] first.
REQ-008 pending_auth_request_PD_erase / pending_auth_request_DEBUG_erase  out  1 each  one-cycle pulse: source byte consumed.
REQ-009 PD_ready / DEBUG_ready  out  1 each  one-cycle pulse: all fields of that source served without error.
REQ-010 auth_msg_out  out  MSG_LEN  request message to host.
REQ-011 auth_msg_ready  out  1  auth_msg_out valid.
REQ-012 Ack_in_driver  in  1  host accepted auth_msg_out.
REQ-013 resp_req_in  in  1  host response available on auth_msg_in.
REQ-014 resp_req_out  out  1  one-cycle pop of host response.
REQ-015 auth_msg_in  in  MSG_LEN  host response message.
REQ-016 auth_resp_data  out  MSG_LEN  last accepted response; auth_resp_valid  out  1  one-cycle pulse per accepted response.
REQ-017 auth_error  out  1  sticky error flag.

Function
REQ-018 Field codes SHALL be: 00 none, 01 GET_DIGESTS (0x81), 10 GET_CERTIFICATE (0x82), 11 CHALLENGE (0x83).
REQ-019 Message SHALL be {8'h01 version, type, param1 = field index, param2 = chunk index, zeros}, MSG upper bytes first.
REQ-020 States SHALL be IDLE, DECODE, SEND, WAIT_RESP, CHECK, DONE, ERROR.
REQ-021 IDLE: PD_msg_ready=1 -> latch PD byte, DECODE; else DEBUG_msg_ready=1 -> latch DEBUG byte, DECODE; PD wins ties.
REQ-022 DECODE: lowest-index nonzero field -> build message, chunk=0, SEND; no nonzero field -> DONE.
REQ-023 SEND: auth_msg_ready=1, auth_msg_out stable; Ack_in_driver sampled 1 -> WAIT_RESP, auth_msg_ready 0 next cycle.
REQ-024 WAIT_RESP: resp_req_in sampled 1 -> resp_req_out=1 for exactly that one cycle, auth_msg_in captured same edge, CHECK.
REQ-025 CHECK: bytes [MSG_LEN-1:MSG_LEN-16] == {8'h01, request type} -> auth_resp_valid pulse; mismatch -> ERROR.
REQ-026 After accepted GET_CERTIFICATE chunk < CERT_CHUNKS-1: chunk+1, SEND; otherwise clear field, DECODE.
REQ-027 DONE: pulse source erase and source ready together, IDLE next cycle.
REQ-028 ERROR: auth_error=1, pulse source erase only, IDLE next cycle.
REQ-029 Timeout counter SHALL reload on entry to SEND and WAIT_RESP; reaching TIMEOUT_CYCLES -> ERROR.
REQ-030 auth_error SHALL clear on the cycle a new byte is latched in IDLE.
REQ-031 Source inputs SHALL be ignored outside IDLE; a request held through service is served again after erase only if still asserted.

Reset
REQ-032 On reset: state IDLE, all outputs 0, auth_msg_out/auth_resp_data 0, counters 0, latched byte discarded, no erase pulse.
REQ-033 Reset mid-transaction SHALL abort immediately; first possible new latch on first clk edge after deassertion.

Configuration
REQ-034 Macro AUTH_DEBUG_PORT_EN defined: DEBUG source arbitrated per REQ-021.
REQ-035 Undefined: DEBUG inputs ignored; DEBUG_ready and pending_auth_request_DEBUG_erase tied 0.

Structure
REQ-036 Shared package/include: MSG_LEN, version 8'h01, request type codes, field codes, state encoding.
REQ-037 One sub-module: auth_timeout_counter (load, enable, expired).

Verification
REQ-038 PD byte 8'h03, prompt ack/resp {01,83} -> one CHALLENGE message, one auth_resp_valid, erase+PD_ready pulse.
REQ-039 PD byte {00,10,00,11}, host echoes correct headers -> CHALLENGE then 6 GET_CERTIFICATE messages chunk 0..5, param1=2, then PD_ready.
REQ-040 PD and DEBUG asserted same cycle -> PD served fully first, then DEBUG (macro defined); DEBUG ignored (undefined).
REQ-041 Ack_in_driver held 0 -> auth_msg_ready high 1024 cycles, then auth_error=1, PD erase, no PD_ready.
REQ-042 Response header {01,81} to 0x82 request -> no auth_resp_valid, auth_error=1, erase pulse.
REQ-043 reset asserted in WAIT_RESP -> all outputs 0 asynchronously, no erase; new request accepted after release.
